alu_serial_bcd: RTL



---
 rtl/alu_serial_bcd.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_serial_bcd.sv
// Nibble-serial binary/BCD ALU with start/busy/done handshake, one digit per RDY cycle, LSB first.
// Define ALU_FAST_LOGIC_EN to finish logic/pass/rotate ops in a single cycle instead of NIB cycles.
module alu_serial_bcd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RDY,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             right,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             BCD,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT,
  output logic             CO,
  output logic             HC,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   k;
  logic [WIDTH:0]  l_q;
  logic [WIDTH-1:0] b_q;
  logic            c_q, dec_q, sub_q, logic_q;

  logic [WIDTH-1:0] lr;
  logic [WIDTH:0]   l_in;
  logic [WIDTH-1:0] b_in;
  logic             accept, last, fast_go;
  logic [3:0]       l_nib, b_nib, digit;
  logic [4:0]       s;
  logic             c_next;

`ifdef ALU_FAST_LOGIC_EN
  assign fast_go = logic_q;
`else
  assign fast_go = 1'b0;
`endif

  // Operand shaping done once at accept; the adder only ever sees L + B' + c.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lr = AI;
    case (op[1:0])
      2'b00:   lr = AI | BI;
      2'b01:   lr = AI & BI;
      2'b10:   lr = AI ^ BI;
      default: lr = AI;
    endcase
    l_in = right ? {AI[0], CI, AI[WIDTH-1:1]} : {1'b0, lr};
    case (op[3:2])
      2'b00:   b_in = BI;
      2'b01:   b_in = ~BI;
      2'b10:   b_in = l_in[WIDTH-1:0];
      default: b_in = '0;
    endcase
  end

  // One digit slice of the adder plus decimal adjust.
  always_comb begin
    l_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k == CW'(i)) begin
        l_nib = l_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    s      = {1'b0, l_nib} + {1'b0, b_nib} + {4'b0, c_q};
    digit  = s[3:0];
    c_next = s[4];
    if (dec_q && !sub_q) begin
      if (s > 5'd9) begin
        digit  = s[3:0] + 4'd6;
        c_next = 1'b1;
      end
    end else if (dec_q && sub_q) begin
      if (!s[4]) digit = s[3:0] + 4'd10;
    end
  end

  assign last = (k == CW'(NIB - 1));

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN:  if (last || fast_go) state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    if (reset)    state <= IDLE;
    else if (RDY) state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      l_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      dec_q   <= 1'b0;
      sub_q   <= 1'b0;
      logic_q <= 1'b0;
      OUT     <= '0;
      CO      <= 1'b0;
      HC      <= 1'b0;
      V       <= 1'b0;
      N       <= 1'b0;
    end else if (RDY) begin
      if (accept) begin
        k       <= '0;
        l_q     <= l_in;
        b_q     <= b_in;
        c_q     <= (right || op[3:2] == 2'b11) ? 1'b0 : CI;
        dec_q   <= BCD && (op == 4'b0011 || op == 4'b0111);
        sub_q   <= (op == 4'b0111);
        logic_q <= (op[3:2] == 2'b11);
      end else if (state == RUN) begin
        if (fast_go) begin
          OUT <= l_q[WIDTH-1:0];
          CO  <= l_q[WIDTH];
          HC  <= 1'b0;
          V   <= 1'b0;
          N   <= l_q[WIDTH-1];
        end else begin
          k   <= k + CW'(1);
          c_q <= c_next;
          for (int i = 0; i < NIB; i++) begin
            if (k == CW'(i)) OUT[4*i +: 4] <= digit;
          end
          if (k == '0) HC <= c_next;
          if (last) begin
            CO <= logic_q ? l_q[WIDTH] : (c_next | l_q[WIDTH]);
            // Overflow is carry-in ^ carry-out of the top bit, taken from the unadjusted sum.
            V  <= l_nib[3] ^ b_nib[3] ^ s[4] ^ s[3];
            N  <= digit[3];
          end
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign Z    = (OUT == '0);

endmodule
